// File: rtl/mem_wb_stage_pkg.sv
// Shared register-file write-back definitions: polarities, widths, load op encodings.
package mem_wb_stage_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        StallActive = 1'b1;
    localparam logic        FlushActive = 1'b1;
    localparam int          RegAddrBus  = 5;
    localparam int          RegBus      = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_op_e;

    // Codes 6 and 7 are unassigned and must never produce a register write.
    function automatic logic is_reserved_op(input logic [2:0] op);
        return (op == 3'd6) || (op == 3'd7);
    endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian byte/halfword extraction and sign/zero extension of a load word.
// Purely combinational; non-load ops pass the ALU result through.
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]        load_op,
    input  logic [1:0]        addr_lo,
    input  logic [RegBus-1:0] rdata,
    input  logic [RegBus-1:0] alu_data,
    output logic [RegBus-1:0] wdata
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = rdata[31:24];
        case (addr_lo)
            2'd1:    byte_val = rdata[23:16];
            2'd2:    byte_val = rdata[15:8];
            2'd3:    byte_val = rdata[7:0];
            default: byte_val = rdata[31:24];
        endcase
        // Halfwords are aligned upstream, so only addr_lo[1] matters.
        half_val = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        wdata = ZeroWord;
        case (load_op)
            LOAD_NONE: wdata = alu_data;
            LOAD_LB:   wdata = {{24{byte_val[7]}}, byte_val};
            LOAD_LBU:  wdata = {24'h000000, byte_val};
            LOAD_LH:   wdata = {{16{half_val[15]}}, half_val};
            LOAD_LHU:  wdata = {16'h0000, half_val};
            LOAD_LW:   wdata = rdata;
            default:   wdata = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register driving the register-file write port, 1-cycle latency.
// Flush and MEM-only stalls insert bubbles; a full MEM+WB stall holds the outputs.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_load_op,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_wdata
);

    logic [DATA_W-1:0] aligned_data;

    load_align u_load_align (
        .load_op  (mem_load_op),
        .addr_lo  (mem_addr_lo),
        .rdata    (mem_rdata),
        .alu_data (mem_wdata),
        .wdata    (aligned_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            wb_waddr <= '0;
            wb_we    <= 1'b0;
            wb_wdata <= ZeroWord;
        end else if (flush == FlushActive) begin
            wb_waddr <= '0;
            wb_we    <= 1'b0;
            wb_wdata <= ZeroWord;
        end else if (stall_mem == StallActive) begin
            // WB still running while MEM is stuck: drain a bubble so nothing is written twice.
            if (stall_wb != StallActive) begin
                wb_waddr <= '0;
                wb_we    <= 1'b0;
                wb_wdata <= ZeroWord;
            end
        end else if (is_reserved_op(mem_load_op)) begin
            wb_waddr <= '0;
            wb_we    <= 1'b0;
            wb_wdata <= ZeroWord;
        end else begin
            wb_waddr <= mem_waddr;
            wb_we    <= (mem_we == WriteEnable) && (mem_waddr != '0);
            wb_wdata <= aligned_data;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed cases plus a random stream against a reference model.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_waddr   (mem_waddr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_load_op (mem_load_op),
        .mem_addr_lo (mem_addr_lo),
        .mem_rdata   (mem_rdata),
        .stall_mem   (stall_mem),
        .stall_wb    (stall_wb),
        .flush       (flush),
        .wb_waddr    (wb_waddr),
        .wb_we       (wb_we),
        .wb_wdata    (wb_wdata)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] target;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    // Reference model state: what the write port should show after the next edge.
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] rd, input logic [31:0] alu);
        logic [31:0] b;
        logic [31:0] h;
        int          bsh;
        int          hsh;
        bsh = 8 * (3 - int'(lo));
        hsh = lo[1] ? 0 : 16;
        b = (rd >> bsh) & 32'h0000_00FF;
        h = (rd >> hsh) & 32'h0000_FFFF;
        case (op)
            3'd1:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            3'd5:    return rd;
            default: return alu;
        endcase
    endfunction

    task automatic push(input string nm, input logic we, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.target = 32'(cyc + 1);
        e.we     = we;
        e.waddr  = a;
        e.wdata  = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic set_idle();
        mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'h0; mem_load_op = 3'd0;
        mem_addr_lo = 2'd0; mem_rdata = 32'h0; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
    endtask

    task automatic model_clear();
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'h0;
    endtask

    // Presents one MEM-stage cycle and records what the write port must show after the edge.
    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [2:0] op, input logic [1:0] lo, input logic [31:0] rd,
                         input logic sm, input logic sw, input logic fl);
        @(posedge clk);
        #1;
        mem_we = we; mem_waddr = a; mem_wdata = d; mem_load_op = op;
        mem_addr_lo = lo; mem_rdata = rd; stall_mem = sm; stall_wb = sw; flush = fl;
        if (fl || (sm && !sw) || (!sm && op >= 3'd6)) begin
            model_clear();
        end else if (!sm) begin
            m_we    = we && (a != 5'd0);
            m_waddr = a;
            m_wdata = ref_load(op, lo, rd, d);
        end
        push("model", m_we, m_waddr, m_wdata);
    endtask

    task automatic check_now(input string nm, input logic we, input logic [4:0] a, input logic [31:0] d);
        n_cmp++;
        if (wb_we !== we || wb_waddr !== a || wb_wdata !== d) begin
            n_bad++;
            $display("FAIL %s: got we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
                     nm, wb_we, wb_waddr, wb_wdata, we, a, d);
        end
    endtask

    // Monitor: after every edge, retire all expectations that belong to it.
    initial forever begin
        @(posedge clk);
        #3;
        while (exp_q.size() > 0 && int'(exp_q[0].target) <= cyc) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (int'(e.target) != cyc || wb_we !== e.we || wb_waddr !== e.waddr || wb_wdata !== e.wdata) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h (edge %0d)",
                         nm, cyc, wb_we, wb_waddr, wb_wdata, e.we, e.waddr, e.wdata, e.target);
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(stall_wb && !stall_mem))
        else $error("illegal stall combination: stall_wb without stall_mem");

    assert property (@(posedge clk) disable iff (rst)
        (!flush && !stall_mem && mem_load_op >= 3'd6) |=> !wb_we)
        else $error("reserved load op produced a register write");

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        rst = 1'b1;
        set_idle();
        model_clear();
        #12;
        check_now("reset_state", 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset while a write is pending on the port.
        drive(1'b1, 5'd3, 32'hAAAA_5555, 3'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        push("pre_reset", 1'b1, 5'd3, 32'hAAAA_5555);
        @(posedge clk);
        #4;
        rst = 1'b1;
        set_idle();
        #1;
        check_now("async_reset", 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check_now("reset_hold", 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        model_clear();

        drive(1'b1, 5'd5, 32'h1234_5678, 3'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        push("first_capture", 1'b1, 5'd5, 32'h1234_5678);

        // Byte/halfword extraction from one word.
        drive(1'b1, 5'd7, 32'h5555_5555, 3'd1, 2'd0, RD, 1'b0, 1'b0, 1'b0); push("lb_0",  1'b1, 5'd7, 32'hFFFF_FF80);
        drive(1'b1, 5'd7, 32'h5555_5555, 3'd1, 2'd1, RD, 1'b0, 1'b0, 1'b0); push("lb_1",  1'b1, 5'd7, 32'hFFFF_FFFF);
        drive(1'b1, 5'd7, 32'h5555_5555, 3'd1, 2'd2, RD, 1'b0, 1'b0, 1'b0); push("lb_2",  1'b1, 5'd7, 32'h0000_007F);
        drive(1'b1, 5'd7, 32'h5555_5555, 3'd1, 2'd3, RD, 1'b0, 1'b0, 1'b0); push("lb_3",  1'b1, 5'd7, 32'h0000_0001);
        drive(1'b1, 5'd7, 32'h5555_5555, 3'd2, 2'd1, RD, 1'b0, 1'b0, 1'b0); push("lbu_1", 1'b1, 5'd7, 32'h0000_00FF);
        drive(1'b1, 5'd7, 32'h5555_5555, 3'd3, 2'd0, RD, 1'b0, 1'b0, 1'b0); push("lh_0",  1'b1, 5'd7, 32'hFFFF_80FF);
        drive(1'b1, 5'd7, 32'h5555_5555, 3'd3, 2'd1, RD, 1'b0, 1'b0, 1'b0); push("lh_lo0_ignored", 1'b1, 5'd7, 32'hFFFF_80FF);
        drive(1'b1, 5'd7, 32'h5555_5555, 3'd4, 2'd2, RD, 1'b0, 1'b0, 1'b0); push("lhu_2", 1'b1, 5'd7, 32'h0000_7F01);
        drive(1'b1, 5'd7, 32'h5555_5555, 3'd5, 2'd0, RD, 1'b0, 1'b0, 1'b0); push("lw",    1'b1, 5'd7, 32'h80FF_7F01);

        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 3'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        push("reg0_suppress", 1'b0, 5'd0, 32'hDEAD_BEEF);
        drive(1'b0, 5'd4, 32'h0, 3'd2, 2'd3, RD, 1'b0, 1'b0, 1'b0);
        push("load_no_we", 1'b0, 5'd4, 32'h0000_0001);

        // Full stall holds, MEM-only stall bubbles, then a fresh capture.
        drive(1'b1, 5'd10, 32'hCAFE_F00D, 3'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        push("pre_stall", 1'b1, 5'd10, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd20 + 5'(i), $urandom, 3'd5, 2'd0, $urandom, 1'b1, 1'b1, 1'b0);
            push("stall_hold", 1'b1, 5'd10, 32'hCAFE_F00D);
        end
        drive(1'b1, 5'd21, 32'h7777_7777, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        push("stall_bubble", 1'b0, 5'd0, 32'h0);
        drive(1'b1, 5'd11, 32'h1111_1111, 3'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        push("post_stall", 1'b1, 5'd11, 32'h1111_1111);

        drive(1'b1, 5'd9, 32'h9999_9999, 3'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        push("flush_capture", 1'b0, 5'd0, 32'h0);
        drive(1'b1, 5'd12, 32'h1212_1212, 3'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        push("pre_flush", 1'b1, 5'd12, 32'h1212_1212);
        drive(1'b1, 5'd12, 32'h1212_1212, 3'd0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b1);
        push("flush_over_hold", 1'b0, 5'd0, 32'h0);

        drive(1'b1, 5'd13, 32'h1313_1313, 3'd6, 2'd0, RD, 1'b0, 1'b0, 1'b0);
        push("reserved_op", 1'b0, 5'd0, 32'h0);

        for (int i = 0; i < 1000; i++) begin
            logic       sm;
            logic       sw;
            logic       fl;
            logic [2:0] op;
            sm = ($urandom_range(0, 3) == 0);
            sw = sm ? 1'($urandom_range(0, 1)) : 1'b0;
            fl = ($urandom_range(0, 15) == 0);
            op = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, op,
                  2'($urandom_range(0, 3)), $urandom, sm, sw, fl);
        end

        repeat (3) @(posedge clk);
        #5;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between MEM and the register-file write port. It captures the MEM-stage result once per cycle.
- For load ops it extracts and extends the addressed byte or halfword from the data-memory read word.
- It drives the single write port (waddr/wdata/we) of the register file one cycle later.
- It obeys the stall/flush controller, so stalled instructions are never written twice or lost.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- mem_waddr  in  ADDR_W  destination register from MEM.
- mem_we  in  1  register write request from MEM.
- mem_wdata  in  DATA_W  ALU/move result from MEM (used when not a load).
- mem_load_op  in  3  0=NONE, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW; 6 and 7 are reserved.
- mem_addr_lo  in  2  low two bits of the load effective address.
- mem_rdata  in  DATA_W  aligned word returned by data memory this cycle.
- stall_mem  in  1  MEM stage stalled this cycle.
- stall_wb  in  1  WB stage stalled this cycle.
- flush  in  1  exception/eret flush; highest priority.
- wb_waddr  out  ADDR_W  register-file write address.
- wb_we  out  1  register-file write enable.
- wb_wdata  out  DATA_W  register-file write data.

Behaviour:
- Reset (async, rst=1): wb_waddr=0, wb_we=0, wb_wdata=0 immediately, and they hold while rst is high.
- Reset mid-stream discards the in-flight result; no write occurs.
- Update priority on each rising edge:
  1. flush=1 -> insert bubble (wb_we=0, wb_waddr=0, wb_wdata=0).
  2. stall_mem=1 and stall_wb=0 -> insert bubble, so a stalled MEM instruction is not written.
  3. stall_mem=1 and stall_wb=1 -> hold all outputs unchanged.
  4. stall_mem=0 -> capture the MEM result.
- stall_wb=1 with stall_mem=0 is illegal from the controller. The block captures in that case; the bench asserts it never occurs.
- Latency: exactly 1 cycle from MEM inputs to wb_* outputs. No combinational path from any input to any output.
- Capture rules:
  - wb_we = mem_we and (mem_waddr != 0). A write to register 0 is suppressed here; wb_waddr still latches mem_waddr.
  - Load data is big-endian. addr_lo=0 selects bits 31:24, 1 selects 23:16, 2 selects 15:8, 3 selects 7:0.
  - Halfword loads use addr_lo[1] only: 0 selects bits 31:16, 1 selects 15:0. Misalignment is trapped upstream; addr_lo[0] is ignored.
  - LB/LH sign-extend to 32 bits. LBU/LHU zero-extend.
  - LW passes mem_rdata unchanged.
  - NONE passes mem_wdata.
  - Reserved op codes 6/7 -> captured as a bubble (wb_we=0) and flagged by a bench assertion.
- A load op with mem_we=0 still updates wb_wdata but produces no write.
- Flush together with a stall: flush wins (bubble).
- Back-to-back captures: each edge with stall_mem=0 overwrites the outputs. No buffering beyond one entry.

Decomposition:
- Shared defines header (extends the existing one):
  - RstEnable, WriteEnable, ZeroWord, RegAddrBus, RegBus.
  - Load op encodings LOAD_NONE..LOAD_LW.
  - Stall/flush polarity constants.
- One combinational sub-module, load_align (inputs load_op, addr_lo, rdata, alu_data; output wdata), instantiated before the register. It is reusable by a future LWL/LWR extension.

Test Plan:
- Reset: assert rst mid-cycle while wb_we=1 -> outputs go to 0 without waiting for a clock edge. Release, then capture waddr=5, wdata=0x12345678, op=NONE, we=1 -> next cycle wb_waddr=5, wb_wdata=0x12345678, wb_we=1.
- Byte/halfword extraction: mem_rdata=0x80FF7F01, repeated per addr_lo:
  - LB with addr_lo 0/1/2/3 -> 0xFFFFFF80 / 0xFFFFFFFF / 0x0000007F / 0x00000001.
  - LBU addr_lo=1 -> 0x000000FF.
  - LH addr_lo=0 -> 0xFFFF80FF.
  - LHU addr_lo=2 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Register 0: we=1, waddr=0, wdata=0xDEADBEEF -> wb_we=0.
- Stalls: with an instruction captured, stall_mem=1 and stall_wb=1 for 3 cycles -> outputs held identical. Then stall_mem=1, stall_wb=0 for 1 cycle -> bubble (wb_we=0). Then stall_mem=0 -> new capture.
- Flush: flush=1 together with stall_mem=0, we=1, waddr=9 -> wb_we=0, wb_waddr=0, wb_wdata=0. Flush=1 with stall_mem=stall_wb=1 -> bubble, not hold.
- Random stream of 1000 ops checked against a reference model of the priority rules, with assertions for the illegal stall combination and reserved op codes.
